restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal range 4..64.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  one-cycle request; operands sampled with it.
REQ-005 Port: Dividend  input  WIDTH  numerator.
REQ-006 Port: Divisor  input  WIDTH  denominator.
REQ-007 Port: busy  output  1  high while an operation is in progress.
REQ-008 Port: done  output  1  one-cycle pulse; results valid.
REQ-009 Port: Quotient  output  WIDTH  registered quotient, held until next completion.
REQ-010 Port: Remainder  output  WIDTH  registered remainder, held until next completion.
REQ-011 Port: DivByZero  output  1  set with done when the sampled Divisor was 0; held with results.

Function
REQ-012 FSM states: IDLE, RUN, FIN; reset state IDLE.
REQ-013 IDLE/FIN + start=1 at edge t0: latch operands, partial remainder=0, iteration counter=0, go RUN, busy=1 from t0.
REQ-014 RUN iteration, once per cycle: shift {rem,quot} left 1; trial = rem - divisor at WIDTH+1 bits; borrow=0 -> rem=trial, quot LSB=1; borrow=1 -> rem restored, quot LSB=0.
REQ-015 Exactly WIDTH iterations, at edges t0+1..t0+WIDTH; Quotient/Remainder/DivByZero updated at t0+WIDTH; state -> FIN.
REQ-016 FIN lasts one cycle: done=1, busy=0; then IDLE unless start=1 (back-to-back accepted, REQ-013).
REQ-017 start while in RUN is ignored; latched operands and counter unaffected.
REQ-018 Divisor=0 at start: no iterations; at t0+1 Quotient=all ones, Remainder=Dividend, DivByZero=1, state FIN.
REQ-019 DivByZero=0 for every non-zero-divisor completion.
REQ-020 Outputs change only at completion; Quotient/Remainder/DivByZero stable between done pulses.
REQ-021 Dividend < Divisor: Quotient=0, Remainder=Dividend, normal latency.

Reset
REQ-022 rst_n=0 at any time, mid-RUN included: state IDLE, busy=0, done=0, Quotient=0, Remainder=0, DivByZero=0, counter=0, immediately and without clk.
REQ-023 An aborted operation never raises done; first start after rst_n release behaves per REQ-013.

Configuration
REQ-024 Macro DIV_SIGNED_EN defined: extra port Signed  input  1, sampled with start; Signed=1 selects two's-complement division.
REQ-025 Signed mode: magnitudes divided per REQ-014; Quotient negated iff operand signs differ; Remainder takes the sign of Dividend (truncating division); latency unchanged.
REQ-026 Signed mode: most-negative / -1 -> Quotient=most-negative (wrap), Remainder=0, DivByZero=0; divide-by-zero per REQ-018.
REQ-027 DIV_SIGNED_EN undefined: no Signed port, unsigned-only, no sign-correction logic.

Verification (WIDTH=32)
REQ-028 start, 100/7 -> busy 32 cycles, done at t0+32..t0+33, Quotient=14, Remainder=2, DivByZero=0.
REQ-029 start, 0xFFFFFFFF/1 -> Quotient=0xFFFFFFFF, Remainder=0; immediate back-to-back start 9/3 in FIN cycle -> Quotient=3, Remainder=0 after further 32 cycles.
REQ-030 start, 5/0 -> done at t0+1..t0+2, Quotient=0xFFFFFFFF, Remainder=5, DivByZero=1.
REQ-031 start 100/7, second start 50/5 at t0+10 -> ignored, single done, Quotient=14, Remainder=2.
REQ-032 start 100/7, rst_n=0 at t0+15 -> outputs zero at once, no done; after release, 20/6 -> Quotient=3, Remainder=2.
REQ-033 DIV_SIGNED_EN, Signed=1: -7/2 -> Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> Quotient=0x80000000, Remainder=0.

Source files
------------

// File: rtl/restoring_divider.sv
// Restoring divider: one quotient bit per cycle, WIDTH iterations per operation.
// Optional two's-complement support when DIV_SIGNED_EN is defined (adds the Signed port).
module restoring_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef DIV_SIGNED_EN
  input  logic             Signed,
`endif
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             zero_q, zero_d;
  logic             busy_d, done_d, dbz_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fin, r_fin;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] quot_nx, rem_nx;

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic a_neg, b_neg;

  // Operand magnitudes and result sign selection for two's-complement mode
  assign a_neg = Signed & Dividend[WIDTH-1];
  assign b_neg = Signed & Divisor[WIDTH-1];
  assign a_mag = a_neg ? (WIDTH'(0) - Dividend) : Dividend;
  assign b_mag = b_neg ? (WIDTH'(0) - Divisor) : Divisor;
  assign q_fin = qneg_q ? (WIDTH'(0) - quot_nx) : quot_nx;
  assign r_fin = rneg_q ? (WIDTH'(0) - rem_nx) : rem_nx;
`else
  assign a_mag = Dividend;
  assign b_mag = Divisor;
  assign q_fin = quot_nx;
  assign r_fin = rem_nx;
`endif

  // One restoring step: shift {rem,quot} left, trial-subtract, restore on borrow
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
  assign quot_nx = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
  assign rem_nx  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvsr_d      = dvsr_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    zero_d      = zero_q;
    busy_d      = busy;
    done_d      = 1'b0;
    dbz_d       = DivByZero;
    quotient_d  = Quotient;
    remainder_d = Remainder;
`ifdef DIV_SIGNED_EN
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
`endif
    case (state_q)
      IDLE, FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          rem_d   = '0;
          zero_d  = (Divisor == '0);
          dvsr_d  = b_mag;
          // A zero divisor keeps the raw dividend so it can be returned as remainder
          quot_d  = (Divisor == '0) ? Dividend : a_mag;
`ifdef DIV_SIGNED_EN
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
`endif
        end
      end
      RUN: begin
        if (zero_q) begin
          state_d     = FIN;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          dbz_d       = 1'b1;
          quotient_d  = '1;
          remainder_d = quot_q;
        end else begin
          quot_d = quot_nx;
          rem_d  = rem_nx;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d     = FIN;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            dbz_d       = 1'b0;
            quotient_d  = q_fin;
            remainder_d = r_fin;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvsr_q    <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      zero_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      DivByZero <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
`ifdef DIV_SIGNED_EN
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvsr_q    <= dvsr_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      zero_q    <= zero_d;
      busy      <= busy_d;
      done      <= done_d;
      DivByZero <= dbz_d;
      Quotient  <= quotient_d;
      Remainder <= remainder_d;
`ifdef DIV_SIGNED_EN
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
`endif
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider (WIDTH=32); signed cases run when DIV_SIGNED_EN is defined.
module tb_restoring_divider;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sgn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int   total = 0;
  int   bad   = 0;
  exp_t scb[$];
  exp_t held;

  restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef DIV_SIGNED_EN
    .Signed    (sgn),
`endif
    .Dividend  (dividend),
    .Divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .Quotient  (quotient),
    .Remainder (remainder),
    .DivByZero (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sd;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else if (s) begin
      sa  = longint'($signed(a));
      sd  = longint'($signed(b));
      e.q = W'(sa / sd);
      e.r = W'(sa % sd);
      e.z = 1'b0;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pop and compare on done, otherwise outputs must hold the last result
  always @(negedge clk) begin
    if (!rst_n) begin
      held = '0;
    end else if (done) begin
      if (scb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        held = scb.pop_front();
        check("quotient", 64'(quotient), 64'(held.q));
        check("remainder", 64'(remainder), 64'(held.r));
        check("divbyzero", 64'(dbz), 64'(held.z));
      end
    end else begin
      check("hold_q", 64'(quotient), 64'(held.q));
      check("hold_r", 64'(remainder), 64'(held.r));
      check("hold_z", 64'(dbz), 64'(held.z));
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sgn      = s;
    if (push) scb.push_back(model(a, b, s));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  // Counts edges until done is seen; a missing done shows up as a latency mismatch
  task automatic wait_done(input int lat);
    int n;
    n = 0;
    while (!done && n < lat + 5) begin
      check("busy_running", 64'(busy), 64'(1));
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(lat));
    check("busy_at_done", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    start    = 1'b0;
    sgn      = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_q", 64'(quotient), 64'(0));
    check("rst_r", 64'(remainder), 64'(0));
    check("rst_z", 64'(dbz), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 100/7
    start_op(32'd100, 32'd7, 1'b0, 1'b1);
    wait_done(W);
    @(negedge clk);

    // all-ones / 1, then back-to-back 9/3 issued in the done cycle
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    wait_done(W);
    start_op(32'd9, 32'd3, 1'b0, 1'b1);
    wait_done(W);
    repeat (2) @(negedge clk);

    // divide by zero
    start_op(32'd5, 32'd0, 1'b0, 1'b1);
    wait_done(1);
    repeat (3) @(negedge clk);

    // dividend smaller than divisor
    start_op(32'd3, 32'd10, 1'b0, 1'b1);
    wait_done(W);
    @(negedge clk);

    // start during RUN is ignored
    start_op(32'd100, 32'd7, 1'b0, 1'b1);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    wait_done(W - 10);
    repeat (2) @(negedge clk);

    // reset mid-operation: outputs clear without a clock edge and no done appears
    start_op(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_q", 64'(quotient), 64'(0));
    check("abort_r", 64'(remainder), 64'(0));
    check("abort_z", 64'(dbz), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done), 64'(0));
    start_op(32'd20, 32'd6, 1'b0, 1'b1);
    wait_done(W);
    @(negedge clk);

`ifdef DIV_SIGNED_EN
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    wait_done(W);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done(W);
    start_op(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1);
    wait_done(1);
    start_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
    wait_done(W);
    @(negedge clk);
`endif

    // randomized operands, random idle gaps (including none)
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = W'($urandom_range(0, 1000));
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = a + W'(1);
      endcase
      s = 1'b0;
`ifdef DIV_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(a, b, s, 1'b1);
      wait_done((b == '0) ? 1 : W);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(scb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
